amo_seq: RTL and testbench
==========================

AMO_SEQ -- requirements
Module: amo_seq

Interface
REQ-001 The block SHALL take parameter XLEN, default config_pkg::XLEN (64), as the data width, either 32 or 64.
REQ-002 The block SHALL take parameter PA_BITS, default config_pkg::PA_BITS (56), as the physical address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port AmoReqM, input, 1 bit: an AMO is in the Memory stage.
REQ-006 The block SHALL have port AmoFunctM, input, 5 bits: funct7[6:2] of the AMO.
REQ-007 The block SHALL have port AmoWordM, input, 1 bit: 32-bit (.W) operation on RV64, ignored when XLEN=32.
REQ-008 The block SHALL have port FlushM, input, 1 bit: kill the Memory stage instruction.
REQ-009 The block SHALL have port StallW, input, 1 bit: Writeback stall.
REQ-010 The block SHALL have port Rs2M, input, XLEN bits: the source operand.
REQ-011 The block SHALL have port ReadDataM, input, XLEN bits: the cache read data, valid with MemAckM.
REQ-012 The block SHALL have port MemAckM, input, 1 bit: the cache completed the current access.
REQ-013 The block SHALL have port PreLSURWM, output, 2 bits: {read, write} request to the LSU, fed to the LR/SC squash stage.
REQ-014 The block SHALL have port AmoWriteDataM, output, XLEN bits: the computed store data.
REQ-015 The block SHALL have port AmoResultM, output, XLEN bits: the old memory value for rd.
REQ-016 The block SHALL have port AmoStallM, output, 1 bit: hold the pipeline until the AMO completes.
REQ-017 The block SHALL have port IllegalAmoM, output, 1 bit: unsupported funct, a one-cycle pulse.

Function
REQ-018 The block SHALL implement states IDLE, READ, WRITE and DONE.
REQ-019 IDLE -> READ when AmoReqM & ~FlushM & the funct is supported; otherwise the block SHALL stay in IDLE.
REQ-020 On an AmoReqM carrying an unsupported funct, the block SHALL pulse IllegalAmoM for 1 cycle, stay in IDLE and issue no access.
REQ-021 In READ, PreLSURWM SHALL be 2'b10; on MemAckM the block SHALL capture ReadDataM into an old-value register and go to WRITE.
REQ-022 FlushM in READ before MemAckM SHALL return the block to IDLE with no write issued; FlushM in WRITE or DONE SHALL be ignored.
REQ-023 In WRITE, PreLSURWM SHALL be 2'b01 and AmoWriteDataM SHALL be stable; on MemAckM the block SHALL go to DONE.
REQ-024 The block SHALL leave DONE for IDLE on the first cycle with ~StallW.
REQ-025 AmoStallM SHALL be 1 in READ and WRITE, and also in IDLE during the cycle an accepted request arrives; it SHALL be 0 in DONE.
REQ-026 In IDLE and DONE, PreLSURWM SHALL be 2'b00.
REQ-027 Supported functs SHALL be add 00000, swap 00001, xor 00100, or 01000 and and 01100.
REQ-028 With the macro of REQ-035 compiled in, min 10000, max 10100, minu 11000 and maxu 11100 SHALL also be supported.
REQ-029 Arithmetic SHALL be modulo 2^XLEN; add overflow SHALL wrap and never flag.
REQ-030 When XLEN=64 and AmoWordM=1, the block SHALL operate on the low 32 bits only: AmoWriteDataM[63:32] = the old value's [63:32] unchanged, compares SHALL be 32-bit signed/unsigned, and AmoResultM SHALL be the sign-extended old low word.
REQ-031 AmoResultM SHALL hold the captured old value from WRITE through DONE.
REQ-032 A MemAckM arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-033 While reset_n=0, the state SHALL be IDLE and PreLSURWM, AmoWriteDataM, AmoResultM, AmoStallM and IllegalAmoM SHALL all be 0, asynchronously.
REQ-034 Reset mid-operation SHALL abandon the AMO with no further request issued.

Configuration
REQ-035 The macro AMO_MINMAX_EN SHALL control the min/max functs: when defined, min, max, minu and maxu SHALL be supported; when undefined, they SHALL raise IllegalAmoM per REQ-020 and no comparator logic SHALL be present.

Structure
REQ-036 The funct encodings (amo_funct_t enum) and the state enum SHALL live in config_pkg.
REQ-037 The data operation SHALL be one combinational sub-module, amoalu (old value, Rs2M, funct, word -> new value); the FSM and registers SHALL live in amo_seq.

Verification
REQ-038 amoadd.d, mem=0x5, Rs2M=0x3, ack after 2 cycles each -> PreLSURWM sequence 10,10,01,01 then 00; AmoWriteDataM=0x8; AmoResultM=0x5.
REQ-039 amoadd.w, XLEN=64, mem=0x1234_5678_7FFF_FFFF, Rs2M=1 -> AmoWriteDataM=0x1234_5678_8000_0000; AmoResultM=0x0000_0000_7FFF_FFFF.
REQ-040 amominu.d, mem=0xFFFF_FFFF_FFFF_FFFF, Rs2M=2 -> AmoWriteDataM=0x2; the same funct with AMO_MINMAX_EN undefined -> IllegalAmoM=1 for one cycle, PreLSURWM stays 00.
REQ-041 amoswap with FlushM=1 in READ before ack -> IDLE next cycle, no 01 ever driven, AmoStallM=0.
REQ-042 reset_n=0 asserted in WRITE -> all outputs 0 immediately; after release the state is IDLE and a new amoxor completes normally.
REQ-043 StallW=1 for 3 cycles in DONE -> AmoResultM held for those cycles, then IDLE.

Source files
------------

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg -- shared configuration for the AMO sequencer.
//
// Holds the default data/address widths, the AMO funct7[6:2] encodings
// (amo_funct_t), the sequencer state encoding (amo_state_t) and a helper
// that says whether a funct is executable in this build.
//
// Optional feature macro: AMO_MINMAX_EN adds min/max/minu/maxu to the
// supported set. Without it those encodings are reported as illegal.
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int XLEN    = 64;
    localparam int PA_BITS = 56;

    // funct7[6:2] of the RISC-V A-extension AMOs.
    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_funct_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } amo_state_t;

    // True for encodings the sequencer can execute in this build.
    function automatic logic amoSupported(input logic [4:0] funct);
        case (funct)
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND: return 1'b1;
`ifdef AMO_MINMAX_EN
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU:        return 1'b1;
`endif
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amoalu.sv
// -----------------------------------------------------------------------------
// amoalu -- combinational AMO data operation.
//
// Ports:
//   oldValue  in  XLEN  value read from memory
//   rs2       in  XLEN  source operand
//   funct     in  5     amo_funct_t operation
//   word      in  1     32-bit (.W) operation, only meaningful when XLEN=64
//   newValue  out XLEN  value to store back
//
// In word mode only the low 32 bits are computed; the upper half of the
// stored value is the old upper half. Min/max logic exists only when
// AMO_MINMAX_EN is defined.
// -----------------------------------------------------------------------------
module amoalu #(
    parameter int XLEN = config_pkg::XLEN
) (
    input  logic                   [XLEN-1:0] oldValue,
    input  logic                   [XLEN-1:0] rs2,
    input  config_pkg::amo_funct_t            funct,
    input  logic                              word,
    output logic                   [XLEN-1:0] newValue
);
    import config_pkg::*;

    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] res;
    logic            signedCmp;

`ifdef AMO_MINMAX_EN
    logic lessThan;
    assign signedCmp = (funct == AMO_MIN) || (funct == AMO_MAX);
    assign lessThan  = signedCmp ? ($signed(opA) < $signed(opB)) : (opA < opB);
`else
    assign signedCmp = 1'b0;
`endif

    // Word operands are widened so that a full-width compare gives the
    // 32-bit signed/unsigned answer; add/logic ops only use the low word.
    if (XLEN == 64) begin : gRv64
        logic extA;
        logic extB;
        assign extA     = word & signedCmp & oldValue[31];
        assign extB     = word & signedCmp & rs2[31];
        assign opA      = word ? {{32{extA}}, oldValue[31:0]} : oldValue;
        assign opB      = word ? {{32{extB}}, rs2[31:0]}      : rs2;
        assign newValue = word ? {oldValue[63:32], res[31:0]} : res;
    end else begin : gRv32
        assign opA      = oldValue;
        assign opB      = rs2;
        assign newValue = res;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves res unassigned (no latch).
        res = opB;
        case (funct)
            AMO_ADD:            res = opA + opB;
            AMO_SWAP:           res = opB;
            AMO_XOR:            res = opA ^ opB;
            AMO_OR:             res = opA | opB;
            AMO_AND:            res = opA & opB;
`ifdef AMO_MINMAX_EN
            AMO_MIN, AMO_MINU:  res = lessThan ? opA : opB;
            AMO_MAX, AMO_MAXU:  res = lessThan ? opB : opA;
`endif
            default:            res = opB;
        endcase
    end

endmodule

// File: rtl/amo_seq.sv
// -----------------------------------------------------------------------------
// amo_seq -- read-modify-write sequencer for RISC-V atomic memory operations.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   AmoReqM         AMO in the Memory stage
//   AmoFunctM[4:0]  funct7[6:2] of the AMO
//   AmoWordM        .W operation (XLEN=64 only)
//   FlushM          kill the Memory-stage instruction
//   StallW          Writeback stall, holds DONE
//   Rs2M            source operand
//   ReadDataM       cache read data, valid with MemAckM
//   MemAckM         cache completed the current access
//   PreLSURWM[1:0]  {read, write} request to the LSU
//   AmoWriteDataM   computed store data
//   AmoResultM      old memory value for rd (sign-extended for .W)
//   AmoStallM       hold the pipeline until the AMO completes
//   IllegalAmoM     unsupported funct, one-cycle pulse
//
// Optional feature macro: AMO_MINMAX_EN enables min/max/minu/maxu.
// -----------------------------------------------------------------------------
module amo_seq #(
    parameter int XLEN    = config_pkg::XLEN,
    parameter int PA_BITS = config_pkg::PA_BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            AmoReqM,
    input  logic [4:0]      AmoFunctM,
    input  logic            AmoWordM,
    input  logic            FlushM,
    input  logic            StallW,
    input  logic [XLEN-1:0] Rs2M,
    input  logic [XLEN-1:0] ReadDataM,
    input  logic            MemAckM,
    output logic [1:0]      PreLSURWM,
    output logic [XLEN-1:0] AmoWriteDataM,
    output logic [XLEN-1:0] AmoResultM,
    output logic            AmoStallM,
    output logic            IllegalAmoM
);
    import config_pkg::*;

    if ((XLEN != 32 && XLEN != 64) || PA_BITS < 12) begin : gBadConfig
        $error("amo_seq: XLEN must be 32 or 64 and PA_BITS at least 12");
    end

    amo_state_t      state;
    amo_funct_t      functReg;
    logic            wordReg;
    logic [XLEN-1:0] rs2Reg;
    logic [XLEN-1:0] oldValue;
    logic [XLEN-1:0] newValue;
    logic            wordEff;
    logic            inIdle;
    logic            accept;

    if (XLEN == 64) begin : gWord64
        assign wordEff    = AmoWordM;
        assign AmoResultM = wordReg ? {{32{oldValue[31]}}, oldValue[31:0]} : oldValue;
    end else begin : gWord32
        assign wordEff    = 1'b0;
        assign AmoResultM = oldValue;
    end

    // reset_n gates the request decode so the combinational outputs are
    // also held at 0 for the whole reset, not just the registers.
    assign inIdle      = reset_n & (state == IDLE);
    assign accept      = inIdle & AmoReqM & ~FlushM & amoSupported(AmoFunctM);
    assign IllegalAmoM = inIdle & AmoReqM & ~FlushM & ~amoSupported(AmoFunctM);

    assign PreLSURWM = (state == READ)  ? 2'b10 :
                       (state == WRITE) ? 2'b01 : 2'b00;
    assign AmoStallM = (state == READ) | (state == WRITE) | accept;

    // Operands are latched at acceptance so the store data does not depend
    // on the pipeline keeping Rs2M/funct stable during the access.
    amoalu #(.XLEN(XLEN)) uAlu (
        .oldValue (ReadDataM),
        .rs2      (rs2Reg),
        .funct    (functReg),
        .word     (wordReg),
        .newValue (newValue)
    );

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            functReg      <= AMO_ADD;
            wordReg       <= 1'b0;
            rs2Reg        <= '0;
            oldValue      <= '0;
            AmoWriteDataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= READ;
                        functReg <= amo_funct_t'(AmoFunctM);
                        wordReg  <= wordEff;
                        rs2Reg   <= Rs2M;
                    end
                end
                READ: begin
                    // A flush takes priority over a same-cycle ack: the
                    // instruction is dead, so no write may follow.
                    if (FlushM) begin
                        state <= IDLE;
                    end else if (MemAckM) begin
                        state         <= WRITE;
                        oldValue      <= ReadDataM;
                        AmoWriteDataM <= newValue;
                    end
                end
                WRITE: begin
                    if (MemAckM) state <= DONE;
                end
                DONE: begin
                    if (!StallW) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_seq.sv
// -----------------------------------------------------------------------------
// tb_amo_seq -- self-checking bench for amo_seq (XLEN=64).
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later; a cycle index c counts falling edges from request acceptance.
// -----------------------------------------------------------------------------
module tb_amo_seq;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic        clk;
    logic        reset_n;
    logic        AmoReqM;
    logic [4:0]  AmoFunctM;
    logic        AmoWordM;
    logic        FlushM;
    logic        StallW;
    logic [63:0] Rs2M;
    logic [63:0] ReadDataM;
    logic        MemAckM;
    logic [1:0]  PreLSURWM;
    logic [63:0] AmoWriteDataM;
    logic [63:0] AmoResultM;
    logic        AmoStallM;
    logic        IllegalAmoM;

    int compared   = 0;
    int mismatched = 0;

    amo_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .AmoReqM       (AmoReqM),
        .AmoFunctM     (AmoFunctM),
        .AmoWordM      (AmoWordM),
        .FlushM        (FlushM),
        .StallW        (StallW),
        .Rs2M          (Rs2M),
        .ReadDataM     (ReadDataM),
        .MemAckM       (MemAckM),
        .PreLSURWM     (PreLSURWM),
        .AmoWriteDataM (AmoWriteDataM),
        .AmoResultM    (AmoResultM),
        .AmoStallM     (AmoStallM),
        .IllegalAmoM   (IllegalAmoM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Which functs this build must execute.
    function automatic bit ref_legal(input logic [4:0] f);
        bit base;
        base = (f == F_ADD) || (f == F_SWAP) || (f == F_XOR) || (f == F_OR) || (f == F_AND);
`ifdef AMO_MINMAX_EN
        return base || (f == F_MIN) || (f == F_MAX) || (f == F_MINU) || (f == F_MAXU);
`else
        return base;
`endif
    endfunction

    // Reference: architectural AMO semantics on integers.
    function automatic void ref_amo(input logic [4:0] f, input bit w, input logic [63:0] mem,
                                    input logic [63:0] rs2, output logic [63:0] wdata,
                                    output logic [63:0] rd);
        longint          sm, sr;
        longint unsigned um, ur, res;
        if (w) begin
            um = {32'd0, mem[31:0]};
            ur = {32'd0, rs2[31:0]};
            sm = $signed(mem[31:0]);
            sr = $signed(rs2[31:0]);
        end else begin
            um = mem;
            ur = rs2;
            sm = $signed(mem);
            sr = $signed(rs2);
        end
        case (f)
            F_ADD:   res = um + ur;
            F_SWAP:  res = ur;
            F_XOR:   res = um ^ ur;
            F_OR:    res = um | ur;
            F_AND:   res = um & ur;
            F_MIN:   res = (sm < sr) ? um : ur;
            F_MAX:   res = (sm > sr) ? um : ur;
            F_MINU:  res = (um < ur) ? um : ur;
            F_MAXU:  res = (um > ur) ? um : ur;
            default: res = um;
        endcase
        if (w) begin
            wdata = {mem[63:32], res[31:0]};
            rd    = {{32{mem[31]}}, mem[31:0]};
        end else begin
            wdata = res;
            rd    = mem;
        end
    endfunction

    // One complete AMO driven like a stalled pipeline: request and operands
    // held until DONE releases, acks after rdLat/wrLat cycles, StallW held
    // for stallCyc DONE cycles. Optional late flushes and stray acks must
    // have no effect.
    task automatic test_amo_txn(input string name, input logic [4:0] f, input bit w,
                                input logic [63:0] mem, input logic [63:0] rs2,
                                input int rdLat, input int wrLat, input int stallCyc,
                                input bit flushLate, input bit ackNoise);
        logic [63:0] expW, expR;
        logic [1:0]  expRw;
        logic        expStall;
        bit          inRead, inWrite, inDone;
        int          n;
        ref_amo(f, w, mem, rs2, expW, expR);
        n = rdLat + wrLat + stallCyc + 2;
        for (int c = 0; c <= n; c++) begin
            inRead  = (c >= 1) && (c <= rdLat);
            inWrite = (c > rdLat) && (c <= rdLat + wrLat);
            inDone  = (c > rdLat + wrLat) && (c < n);
            @(negedge clk);
            AmoReqM   = (c < n);
            AmoFunctM = (c < n) ? f : 5'($urandom);
            AmoWordM  = (c < n) ? w : 1'($urandom);
            Rs2M      = (c < n) ? rs2 : rand64();
            ReadDataM = (c == rdLat) ? mem : rand64();
            FlushM    = flushLate && (inWrite || inDone);
            StallW    = inDone ? (c <= rdLat + wrLat + stallCyc) : 1'($urandom);
            MemAckM   = (c == rdLat) || (c == rdLat + wrLat) ||
                        (ackNoise && (c == 0 || inDone || c == n) && ($urandom_range(0, 1) == 1));
            #1;
            expRw    = inRead ? 2'b10 : (inWrite ? 2'b01 : 2'b00);
            expStall = (c == 0) || inRead || inWrite;
            compared++;
            if (PreLSURWM !== expRw) begin
                mismatched++;
                $display("FAIL %s.rw c=%0d: got %b want %b", name, c, PreLSURWM, expRw);
            end
            compared++;
            if (AmoStallM !== expStall) begin
                mismatched++;
                $display("FAIL %s.stall c=%0d: got %b want %b", name, c, AmoStallM, expStall);
            end
            compared++;
            if (IllegalAmoM !== 1'b0) begin
                mismatched++;
                $display("FAIL %s.illegal c=%0d: got %b want 0", name, c, IllegalAmoM);
            end
            if (inWrite) begin
                compared++;
                if (AmoWriteDataM !== expW) begin
                    mismatched++;
                    $display("FAIL %s.wdata c=%0d: got %h want %h", name, c, AmoWriteDataM, expW);
                end
            end
            if (inWrite || inDone) begin
                compared++;
                if (AmoResultM !== expR) begin
                    mismatched++;
                    $display("FAIL %s.result c=%0d: got %h want %h", name, c, AmoResultM, expR);
                end
            end
        end
        MemAckM = 1'b0;
        FlushM  = 1'b0;
        StallW  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        AmoReqM   = 1'b1;
        AmoFunctM = F_ADD;
        AmoWordM  = 1'b0;
        FlushM    = 1'b0;
        StallW    = 1'b0;
        Rs2M      = rand64();
        ReadDataM = rand64();
        MemAckM   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (PreLSURWM !== 2'b00) begin mismatched++; $display("FAIL reset.rw: got %b want 00", PreLSURWM); end
        compared++;
        if (AmoWriteDataM !== 64'd0) begin mismatched++; $display("FAIL reset.wdata: got %h want 0", AmoWriteDataM); end
        compared++;
        if (AmoResultM !== 64'd0) begin mismatched++; $display("FAIL reset.result: got %h want 0", AmoResultM); end
        compared++;
        if (AmoStallM !== 1'b0) begin mismatched++; $display("FAIL reset.stall: got %b want 0", AmoStallM); end
        compared++;
        if (IllegalAmoM !== 1'b0) begin mismatched++; $display("FAIL reset.illegal: got %b want 0", IllegalAmoM); end
        @(negedge clk);
        AmoReqM = 1'b0;
        MemAckM = 1'b0;
        reset_n = 1'b1;
        #1;
        compared++;
        if (PreLSURWM !== 2'b00 || AmoStallM !== 1'b0) begin
            mismatched++;
            $display("FAIL reset.release: got rw=%b stall=%b want rw=00 stall=0", PreLSURWM, AmoStallM);
        end
    endtask

    task automatic test_illegal(input string name, input logic [4:0] f);
        @(negedge clk);
        AmoReqM   = 1'b1;
        AmoFunctM = f;
        AmoWordM  = 1'($urandom);
        Rs2M      = rand64();
        FlushM    = 1'b0;
        MemAckM   = 1'b0;
        #1;
        compared++;
        if (IllegalAmoM !== 1'b1) begin mismatched++; $display("FAIL %s.pulse: got %b want 1", name, IllegalAmoM); end
        compared++;
        if (AmoStallM !== 1'b0) begin mismatched++; $display("FAIL %s.stall: got %b want 0", name, AmoStallM); end
        compared++;
        if (PreLSURWM !== 2'b00) begin mismatched++; $display("FAIL %s.rw0: got %b want 00", name, PreLSURWM); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            AmoReqM = 1'b0;
            MemAckM = (c == 1);
            ReadDataM = rand64();
            #1;
            compared++;
            if (PreLSURWM !== 2'b00 || IllegalAmoM !== 1'b0) begin
                mismatched++;
                $display("FAIL %s.after c=%0d: got rw=%b ill=%b want rw=00 ill=0", name, c, PreLSURWM, IllegalAmoM);
            end
        end
        MemAckM = 1'b0;
    endtask

    task automatic test_add_seq();
        test_amo_txn("add_d", F_ADD, 1'b0, 64'h5, 64'h3, 2, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_word_add();
        test_amo_txn("add_w", F_ADD, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'h1, 1, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_minu();
`ifdef AMO_MINMAX_EN
        test_amo_txn("minu_d", F_MINU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1, 2, 0, 1'b0, 1'b0);
`else
        test_illegal("minu_d_disabled", F_MINU);
`endif
    endtask

    task automatic test_flush();
        @(negedge clk);
        AmoReqM   = 1'b1;
        AmoFunctM = F_SWAP;
        AmoWordM  = 1'b0;
        Rs2M      = rand64();
        FlushM    = 1'b0;
        MemAckM   = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            FlushM = (c == 2);
            #1;
            compared++;
            if (PreLSURWM !== 2'b10) begin mismatched++; $display("FAIL flush.read c=%0d: got %b want 10", c, PreLSURWM); end
        end
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            AmoReqM   = 1'b0;
            FlushM    = 1'b0;
            MemAckM   = 1'($urandom);
            ReadDataM = rand64();
            #1;
            compared++;
            if (PreLSURWM !== 2'b00 || AmoStallM !== 1'b0) begin
                mismatched++;
                $display("FAIL flush.after c=%0d: got rw=%b stall=%b want rw=00 stall=0", c, PreLSURWM, AmoStallM);
            end
        end
        // A request flushed in the same cycle it arrives is never accepted.
        @(negedge clk);
        AmoReqM = 1'b1;
        FlushM  = 1'b1;
        MemAckM = 1'b0;
        #1;
        compared++;
        if (AmoStallM !== 1'b0) begin mismatched++; $display("FAIL flush.req_stall: got %b want 0", AmoStallM); end
        @(negedge clk);
        AmoReqM = 1'b0;
        FlushM  = 1'b0;
        #1;
        compared++;
        if (PreLSURWM !== 2'b00) begin mismatched++; $display("FAIL flush.req_rw: got %b want 00", PreLSURWM); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] mem, rs2;
        mem = rand64();
        rs2 = rand64();
        @(negedge clk);
        AmoReqM   = 1'b1;
        AmoFunctM = F_XOR;
        AmoWordM  = 1'b0;
        Rs2M      = rs2;
        FlushM    = 1'b0;
        StallW    = 1'b0;
        MemAckM   = 1'b0;
        @(negedge clk);
        MemAckM   = 1'b1;
        ReadDataM = mem;
        @(negedge clk);
        MemAckM   = 1'b0;
        #1;
        compared++;
        if (PreLSURWM !== 2'b01) begin mismatched++; $display("FAIL rstmid.write: got %b want 01", PreLSURWM); end
        reset_n = 1'b0;
        #1;
        compared++;
        if (PreLSURWM !== 2'b00 || AmoStallM !== 1'b0 || IllegalAmoM !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid.ctrl: got rw=%b stall=%b ill=%b want 0", PreLSURWM, AmoStallM, IllegalAmoM);
        end
        compared++;
        if (AmoWriteDataM !== 64'd0 || AmoResultM !== 64'd0) begin
            mismatched++;
            $display("FAIL rstmid.data: got wdata=%h result=%h want 0", AmoWriteDataM, AmoResultM);
        end
        @(negedge clk);
        #1;
        compared++;
        if (PreLSURWM !== 2'b00 || AmoStallM !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid.hold: got rw=%b stall=%b want 0", PreLSURWM, AmoStallM);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset_n = 1'b1;
            AmoReqM = 1'b0;
            MemAckM = 1'b1;
            #1;
            compared++;
            if (PreLSURWM !== 2'b00 || AmoStallM !== 1'b0) begin
                mismatched++;
                $display("FAIL rstmid.idle c=%0d: got rw=%b stall=%b want 0", c, PreLSURWM, AmoStallM);
            end
        end
        MemAckM = 1'b0;
        test_amo_txn("rstmid_xor", F_XOR, 1'b0, rand64(), rand64(), 1, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stallw();
        test_amo_txn("stallw", F_OR, 1'b0, rand64(), rand64(), 1, 1, 3, 1'b0, 1'b1);
        test_amo_txn("stallw_next", F_AND, 1'b1, rand64(), rand64(), 2, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0]  pool[$];
        logic [4:0]  f;
        logic [63:0] mem, rs2;
        pool = '{F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};
        for (int i = 0; i < 40; i++) begin
            f   = pool[$urandom_range(0, pool.size() - 1)];
            mem = rand64();
            rs2 = rand64();
            case ($urandom_range(0, 3))
                0: rs2 = mem;
                1: rs2[31] = ~mem[31];
                2: rs2[63] = ~mem[63];
                default: ;
            endcase
            if (ref_legal(f)) begin
                test_amo_txn($sformatf("rand%0d", i), f, 1'($urandom), mem, rs2,
                             $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2),
                             1'($urandom), 1'($urandom));
            end else begin
                test_illegal($sformatf("rand%0d_illegal", i), f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_seq();
        test_word_add();
        test_minu();
        test_illegal("lr", 5'b00010);
        test_illegal("sc", 5'b00011);
        test_illegal("f11111", 5'b11111);
        test_flush();
        test_reset_mid();
        test_stallw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
